// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle between the arbiter (master side) and the shared slave fabric.
interface apb_master_arbiter_if;
  logic [31:0] PADDR;
  logic [15:0] PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port among NREQ requesters.
// One single-word transfer at a time; PSEL slot decoded from the address;
// an optional PREADY timeout aborts transfers to hung slaves.
module apb_master_arbiter #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT     = 255,
  parameter int SLOTSEL_LSB = 24
) (
  input  logic                 SYSCLK,
  input  logic                 SYSRST,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ-1:0]      REQ_WRITE,
  input  logic [32*NREQ-1:0]   REQ_ADDR,
  input  logic [32*NREQ-1:0]   REQ_WDATA,
  output logic [NREQ-1:0]      ACK,
  output logic [31:0]          RDATA,
  output logic                 ERR,
  output logic                 BUSY,
  output logic [2:0]           GRANT_ID,
  apb_master_arbiter_if.master apb
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_e;

  localparam bit         TIMEOUT_EN  = (TIMEOUT != 0);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_e            state_q, state_d;
  logic [2:0]        last_q, last_d;
  logic [2:0]        grant_q, grant_d;
  logic [7:0]        wait_q, wait_d;
  logic [31:0]       paddr_q, paddr_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic [15:0]       psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              busy_q, busy_d;

  // Arbitration and field selection signals.
  logic [7:0]        pending;
  logic [2:0]        cand;
  logic              win_found;
  logic [2:0]        win_id;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_write;
  logic [NREQ-1:0]   grant_onehot;

  // Round-robin search from LAST+1; a requester being acknowledged cannot win.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it
    // unassigned -- otherwise synthesis infers a latch.
    pending            = '0;
    pending[NREQ-1:0]  = REQ & ~ack_q;
    cand               = '0;
    win_found          = 1'b0;
    win_id             = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = 3'((int'(last_q) + k) % NREQ);
      if (!win_found && pending[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Winner's request fields and the one-hot ACK pattern of the current grant.
  always_comb begin
    sel_addr     = '0;
    sel_wdata    = '0;
    sel_write    = 1'b0;
    grant_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == 3'(i)) begin
        sel_addr  = REQ_ADDR[32*i +: 32];
        sel_wdata = REQ_WDATA[32*i +: 32];
        sel_write = REQ_WRITE[i];
      end
      if (grant_q == 3'(i)) begin
        grant_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic for the IDLE/SETUP/ACCESS sequence.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    wait_d    = wait_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    ack_d     = '0;
    err_d     = err_q;
    rdata_d   = rdata_q;
    busy_d    = busy_q;

    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          paddr_d  = sel_addr;
          pwdata_d = sel_wdata;
          pwrite_d = sel_write;
          psel_d   = 16'(1) << sel_addr[SLOTSEL_LSB +: 4];
          last_d   = win_id;
          grant_d  = win_id;
          busy_d   = 1'b1;
          state_d  = S_SETUP;
        end
      end

      S_SETUP: begin
        penable_d = 1'b1;
        wait_d    = '0;
        state_d   = S_ACCESS;
      end

      S_ACCESS: begin
        if (apb.PREADY) begin
          rdata_d   = pwrite_q ? 32'h0 : apb.PRDATA;
          err_d     = apb.PSLVERR;
          ack_d     = grant_onehot;
          psel_d    = '0;
          penable_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else if (TIMEOUT_EN && (wait_q == TIMEOUT_CNT)) begin
          // Slave never answered: complete the request with an error.
          rdata_d   = '0;
          err_d     = 1'b1;
          ack_d     = grant_onehot;
          psel_d    = '0;
          penable_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else if (wait_q != 8'hFF) begin
          wait_d = wait_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge SYSCLK) begin
    // NOTE: non-blocking assignments so every flop samples its pre-edge value.
    if (SYSRST) begin
      state_q   <= S_IDLE;
      last_q    <= 3'(NREQ - 1);
      grant_q   <= '0;
      wait_q    <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      wait_q    <= wait_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
    end
  end

  assign ACK         = ack_q;
  assign RDATA       = rdata_q;
  assign ERR         = err_q;
  assign BUSY        = busy_q;
  assign GRANT_ID    = grant_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PWDATA  = pwdata_q;

endmodule
